id_symbol_tx: RTL and testbench

//  Transmit end of the 2-bit symbol interface consumed by the case/memory/gate FSMs.

---
 rtl/id_symbol_tx.sv | 134 +++++++++++++
 tb/tb_id_symbol_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/id_symbol_tx.sv
// Serializes a captured ID MSB-first into 2-bit symbols, each held HOLD clocks.
// Optional trailing checksum symbol (sum of data symbols mod 4) when SEQ_CHECKSUM_EN is defined.
module id_symbol_tx #(
  parameter int ID_W = 18,
  parameter int HOLD = 2
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ID_W-1:0]                id_in,
  output logic [1:0]                     a_out,
  output logic                           a_valid,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(ID_W/2+2)-1:0]    sym_idx
);
  localparam int NSYM = ID_W / 2;
  localparam int SW   = $clog2(NSYM + 2);
  localparam int CW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HLAST = CW'(HOLD - 1);
  localparam logic [SW-1:0] SLAST = SW'(NSYM - 1);

  typedef enum logic [1:0] {IDLE, SEND, CHK, DONE} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] sr, sr_n, sr_sh;
  logic [CW-1:0]   cnt, cnt_n;
  logic [SW-1:0]   sym_n;
  logic [1:0]      a_n;
  logic            v_n, b_n, done_n;
`ifdef SEQ_CHECKSUM_EN
  logic [1:0]      csum, csum_n;
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      sym_idx <= '0;
      a_out   <= '0;
      a_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      sym_idx <= sym_n;
      a_out   <= a_n;
      a_valid <= v_n;
      busy    <= b_n;
      done    <= done_n;
`ifdef SEQ_CHECKSUM_EN
      csum    <= csum_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    sym_n   = sym_idx;
    a_n     = a_out;
    v_n     = a_valid;
    b_n     = busy;
    done_n  = 1'b0;
    sr_sh   = sr << 2;
`ifdef SEQ_CHECKSUM_EN
    csum_n  = csum;
`endif
    case (state)
      IDLE: if (start) begin
        state_n = SEND;
        sr_n    = id_in;
        cnt_n   = '0;
        sym_n   = '0;
        a_n     = id_in[ID_W-1 -: 2];
        v_n     = 1'b1;
        b_n     = 1'b1;
`ifdef SEQ_CHECKSUM_EN
        csum_n  = id_in[ID_W-1 -: 2];
`endif
      end
      SEND, CHK: begin
        // abort wins over any symbol advance
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
          sym_n   = '0;
          a_n     = '0;
          v_n     = 1'b0;
          b_n     = 1'b0;
        end else if (cnt != HLAST) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n = '0;
          if (state == SEND && sym_idx != SLAST) begin
            sr_n  = sr_sh;
            sym_n = sym_idx + SW'(1);
            a_n   = sr_sh[ID_W-1 -: 2];
`ifdef SEQ_CHECKSUM_EN
            csum_n = csum + sr_sh[ID_W-1 -: 2];
`endif
          end else begin
`ifdef SEQ_CHECKSUM_EN
            if (state == SEND) begin
              state_n = CHK;
              sym_n   = SW'(NSYM);
              a_n     = csum;
            end else begin
`endif
              state_n = DONE;
              sym_n   = '0;
              a_n     = '0;
              v_n     = 1'b0;
              b_n     = 1'b0;
              done_n  = 1'b1;
`ifdef SEQ_CHECKSUM_EN
            end
`endif
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_id_symbol_tx.sv
// Bench for id_symbol_tx: HOLD=2 and HOLD=1 instances, frame-level reference model,
// directed vector table, hand sequences and randomized traffic.
module tb_id_symbol_tx;
`ifdef SEQ_CHECKSUM_EN
  localparam int CHKN = 1;
`else
  localparam int CHKN = 0;
`endif
  localparam int ID_W = 18;
  localparam int NSYM = 9;

  typedef struct packed {
    logic [1:0] a;
    logic       v, b, d;
    logic [3:0] idx;
  } outs_t;

  typedef struct {
    logic  st;
    outs_t e;
  } vec_t;

  logic clk = 1'b0, res = 1'b0, start = 1'b0, abort = 1'b0;
  logic [ID_W-1:0] id_in = '0;
  logic [1:0] a0, a1;
  logic v0, v1, b0, b1, d0, d1;
  logic [3:0] i0, i1;

  id_symbol_tx #(.ID_W(ID_W), .HOLD(2)) dut (
    .clk(clk), .res(res), .start(start), .abort(abort), .id_in(id_in),
    .a_out(a0), .a_valid(v0), .busy(b0), .done(d0), .sym_idx(i0));
  id_symbol_tx #(.ID_W(ID_W), .HOLD(1)) dut1 (
    .clk(clk), .res(res), .start(start), .abort(abort), .id_in(id_in),
    .a_out(a1), .a_valid(v1), .busy(b1), .done(d1), .sym_idx(i1));

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input outs_t got, input outs_t exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: a frame is an elapsed-edge count e since the accepted start.
  int        hold [2] = '{2, 1};
  bit        m_act[2];
  int        m_e  [2];
  logic [ID_W-1:0] m_id[2];

  function automatic int flen(input int i);
    return (NSYM + CHKN) * hold[i];
  endfunction

  function automatic logic [1:0] csum(input logic [ID_W-1:0] id);
    int s = 0;
    for (int k = 0; k < NSYM; k++) s += int'((id >> (2 * k)) & 3);
    return 2'(s % 4);
  endfunction

  function automatic outs_t expect_out(input int i);
    outs_t o = '0;
    int sym;
    if (m_act[i] && m_e[i] < flen(i)) begin
      sym   = m_e[i] / hold[i];
      o.a   = (sym < NSYM) ? 2'((m_id[i] >> (ID_W - 2 - 2 * sym)) & 3) : csum(m_id[i]);
      o.v   = 1'b1;
      o.b   = 1'b1;
      o.idx = 4'(sym);
    end else if (m_act[i] && m_e[i] == flen(i)) begin
      o.d = 1'b1;
    end
    return o;
  endfunction

  always @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < 2; i++) m_act[i] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i]) begin
          if (start) begin m_act[i] = 1; m_e[i] = 0; m_id[i] = id_in; end
        end else if (m_e[i] < flen(i) && abort) m_act[i] = 0;
        else if (m_e[i] == flen(i)) m_act[i] = 0;
        else m_e[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_h2", {a0, v0, b0, d0, i0}, expect_out(0));
      chk("model_h1", {a1, v1, b1, d1, i1}, expect_out(1));
    end
  end

  task automatic tick(input logic st, input logic ab, input logic [ID_W-1:0] id);
    start = st; abort = ab; id_in = id;
    @(posedge clk); #1;
  endtask

  vec_t tbl[22];
  int   syms[9] = '{1, 1, 2, 2, 1, 2, 0, 3, 3};
  outs_t z = '0;

  initial begin
    #3 chk("reset_state", {a0, v0, b0, d0, i0}, z);
    #9 res = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) tick(0, 0, '0);

    // Test 1/2/4: 92559, second start at edge 4 ignored, id_in scrambled after capture
    for (int j = 0; j < 22; j++) begin
      tbl[j].st = (j == 0 || j == 4);
      tbl[j].e  = '0;
      if (j < 18) tbl[j].e = {2'(syms[j / 2]), 1'b1, 1'b1, 1'b0, 4'(j / 2)};
      else if (CHKN == 1 && j < 20) tbl[j].e = {2'd3, 1'b1, 1'b1, 1'b0, 4'd9};
      else if (j == 18 + 2 * CHKN) tbl[j].e.d = 1'b1;
    end
    for (int j = 0; j < 22; j++) begin
      tick(tbl[j].st, 0, (j == 0) ? 18'd92559 : 18'($urandom));
      chk($sformatf("vec%0d", j), {a0, v0, b0, d0, i0}, tbl[j].e);
    end
    repeat (3) tick(0, 0, '0);

    // Test 5: abort at edge 6, then restart from symbol 0
    tick(1, 0, 18'd92559);
    repeat (5) tick(0, 0, '0);
    tick(0, 1, '0);
    chk("abort_clear", {a0, v0, b0, d0, i0}, z);
    repeat (25) tick(0, 0, '0);
    tick(1, 0, 18'd92559);
    chk("abort_restart", {a0, v0, b0, d0, i0}, {2'd1, 1'b1, 1'b1, 1'b0, 4'd0});
    repeat (25) tick(0, 0, '0);

    // Test 3: HOLD=1, all-ones; start at DONE-state edge ignored, next edge accepted
    tick(1, 0, 18'h3FFFF);
    chk("ones_first", {a1, v1, b1, d1, i1}, {2'd3, 1'b1, 1'b1, 1'b0, 4'd0});
    for (int e = 1; e < NSYM + CHKN; e++) tick(0, 0, '0);
    tick(0, 0, '0);
    chk("ones_done", {a1, v1, b1, d1, i1}, {2'd0, 1'b0, 1'b0, 1'b1, 4'd0});
    tick(1, 0, 18'h3FFFF);
    chk("start_in_done", {a1, v1, b1, d1, i1}, z);
    tick(1, 0, 18'h3FFFF);
    chk("start_after_done", {a1, v1, b1, d1, i1}, {2'd3, 1'b1, 1'b1, 1'b0, 4'd0});
    repeat (25) tick(0, 0, '0);

    // Test 6: asynchronous reset mid-frame
    tick(1, 0, 18'd92559);
    repeat (4) tick(0, 0, '0);
    #2 res = 1'b0;
    #1 chk("async_rst_h2", {a0, v0, b0, d0, i0}, z);
    chk("async_rst_h1", {a1, v1, b1, d1, i1}, z);
    #2 res = 1'b1;
    repeat (5) tick(0, 0, '0);
    chk("post_rst_idle", {a0, v0, b0, d0, i0}, z);

    // Randomized traffic, checked every cycle against the model
    for (int n = 0; n < 600; n++)
      tick(($urandom % 4) == 0, ($urandom % 14) == 0, 18'($urandom));
    repeat (25) tick(0, 0, '0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
